// File: rtl/trace_pkg.sv
// trace_pkg: shared types, default geometry and the trigger compare helper
// for the trace_capture logic analyser.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DUMP  = 2'd3
    } state_t;

    localparam int WIDTH_DEF    = 16;
    localparam int CHANNELS_DEF = 6;
    localparam int DEPTH_DEF    = 16;

    // Pointer and channel-index widths for the default geometry; instances
    // with other parameters derive their own from DEPTH/CHANNELS.
    localparam int PTR_W = $clog2(DEPTH_DEF);
    localparam int CH_W  = $clog2(CHANNELS_DEF);

    // Operand width of the compare helper; callers zero-extend into it.
    localparam int CMP_W = 64;

    // True when every bit selected by mask agrees between sample and value.
    function automatic logic masked_match(input logic [CMP_W-1:0] sample,
                                          input logic [CMP_W-1:0] value,
                                          input logic [CMP_W-1:0] mask);
        return ((sample ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH rows of one full probe sample each. One synchronous write
// port; the read port is combinational so the sequencer can present the next
// beat on the same edge that retires the current one.
module trace_ram #(
    parameter  int ROW_W = 96,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [ROW_W-1:0] rd_data
);

    logic [ROW_W-1:0] mem [DEPTH];

    // Store one sample row per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture.sv
// trace_capture: arms on a pulse, records probe rows into a circular buffer,
// stops on a masked trigger plus a post-trigger window, then streams the
// retained rows oldest-first as one beat per channel over valid/ready.
module trace_capture
    import trace_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int CHANNELS = CHANNELS_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] probe,
    input  logic                      arm,
    input  logic [CW-1:0]             trig_ch,
    input  logic [WIDTH-1:0]          trig_value,
    input  logic [WIDTH-1:0]          trig_mask,
    input  logic [AW-1:0]             post_count,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      triggered
);

    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_F    = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P    = AW'(1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS-1);

    state_t state, state_n;

    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            fill;
    logic [AW:0]            fill_n;
    logic [AW-1:0]          remaining;
    logic [CW-1:0]          cfg_ch;
    logic [WIDTH-1:0]       cfg_value;
    logic [WIDTH-1:0]       cfg_mask;
    logic [AW-1:0]          cfg_post;
    logic [AW-1:0]          dump_row;
    logic [CW-1:0]          dump_ch;
    logic [AW:0]            rows_left;
    logic [WIDTH-1:0]       trig_sample;
    logic [CHANNELS*WIDTH-1:0] rd_row;
    logic                   match;
    logic                   wr_en;
    logic                   restart;
    logic                   last_accept;

    assign trig_sample = probe[int'(cfg_ch)*WIDTH +: WIDTH];
    assign match       = masked_match(CMP_W'(trig_sample), CMP_W'(cfg_value),
                                      CMP_W'(cfg_mask));
    // A re-arm while capturing discards the cycle's sample and starts over.
    assign restart     = arm && (state != DUMP);
    assign wr_en       = (state == ARMED || state == POST) && !arm;
    assign last_accept = (state == DUMP) && out_valid && out_ready && out_last;
    assign fill_n      = (fill == FILL_MAX) ? fill : fill + ONE_F;
    assign busy        = (state != IDLE);

    trace_ram #(
        .ROW_W (CHANNELS*WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (probe),
        .rd_addr (dump_row),
        .rd_data (rd_row)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (arm) state_n = ARMED;
            ARMED: begin
                if (arm)        state_n = ARMED;
                else if (match) state_n = (cfg_post == '0) ? DUMP : POST;
            end
            POST: begin
                if (arm)                     state_n = ARMED;
                else if (remaining == ONE_P) state_n = DUMP;
            end
            DUMP:    if (last_accept) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Trigger configuration, captured on each accepted arm.
    always_ff @(posedge clk) begin
        if (restart) begin
            cfg_ch    <= trig_ch;
            cfg_value <= trig_value;
            cfg_mask  <= trig_mask;
            cfg_post  <= post_count;
        end
    end

    // Write pointer, fill level, post-trigger countdown and trigger flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            remaining <= '0;
            triggered <= 1'b0;
        end else if (restart) begin
            wr_ptr    <= '0;
            fill      <= '0;
            triggered <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE_P;
                fill   <= fill_n;
            end
            if (state == ARMED && match) begin
                triggered <= 1'b1;
                remaining <= cfg_post;
            end
            if (state == POST) remaining <= remaining - ONE_P;
            if (last_accept)   triggered <= 1'b0;
        end
    end

    // Beat sequencer: dump_row/dump_ch always address the beat that will be
    // loaded next, so an accepted beat is replaced on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            dump_row  <= '0;
            dump_ch   <= '0;
            rows_left <= '0;
        end else if (state != DUMP && state_n == DUMP) begin
            // Entry edge is also the final write: oldest = new wr_ptr - rows.
            dump_row  <= wr_ptr + ONE_P - fill_n[AW-1:0];
            dump_ch   <= '0;
            rows_left <= fill_n;
        end else if (state == DUMP && (!out_valid || out_ready)) begin
            if (rows_left != '0) begin
                out_valid <= 1'b1;
                out_data  <= rd_row[int'(dump_ch)*WIDTH +: WIDTH];
                out_ch    <= dump_ch;
                out_last  <= (rows_left == ONE_F) && (dump_ch == LAST_CH);
                if (dump_ch == LAST_CH) begin
                    dump_ch   <= '0;
                    dump_row  <= dump_row + ONE_P;
                    rows_left <= rows_left - ONE_F;
                end else begin
                    dump_ch <= dump_ch + ONE_C;
                end
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed scenarios for trace_capture with CHANNELS=6,
// WIDTH=16, DEPTH=8; channel c carries cycles-since-arm + 0x100*c.
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] probe;
    logic        arm = 1'b0;
    logic [2:0]  trig_ch = '0;
    logic [15:0] trig_value = '0;
    logic [15:0] trig_mask = '0;
    logic [2:0]  post_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [2:0]  out_ch;
    logic        out_last;
    logic        busy;
    logic        triggered;

    logic [15:0] cyc = '0;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] beats[$];
    int          first_valid;
    bit          dump_done;

    trace_capture #(.WIDTH(16), .CHANNELS(6), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .probe      (probe),
        .arm        (arm),
        .trig_ch    (trig_ch),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .busy       (busy),
        .triggered  (triggered)
    );

    always #5 clk = ~clk;

    // Cycle counter restarts on the arm edge, so the first armed sample is 0.
    always @(posedge clk) begin
        if (arm) cyc <= '0;
        else     cyc <= cyc + 16'd1;
    end

    always_comb begin
        probe = '0;
        for (int c = 0; c < 6; c++) probe[c*16 +: 16] = cyc + 16'(c * 256);
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [2:0] ch, input logic [15:0] val,
                          input logic [15:0] mask, input logic [2:0] post);
        @(negedge clk);
        trig_ch    = ch;
        trig_value = val;
        trig_mask  = mask;
        post_count = post;
        arm        = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1,0; 2: ready high plus an
    // arm pulse mid-dump.
    task automatic collect(input int mode, input int budget);
        int      i;
        bit      stalled;
        logic [19:0] held;
        bit      pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        i = 0;
        stalled = 0;
        held = '0;
        dump_done = 0;
        first_valid = -1;
        beats.delete();
        while (!dump_done && i < budget) begin
            @(negedge clk);
            i++;
            if (stalled)
                chk("stall_hold", {11'b0, out_valid, out_last, out_ch, out_data},
                    {11'b0, 1'b1, held});
            out_ready = (mode == 1) ? pat[i % 5] : 1'b1;
            if (mode == 2) begin
                arm       = (i == 10);
                trig_mask = (i == 10) ? 16'h0000 : trig_mask;
            end
            if (out_valid && first_valid < 0) first_valid = i;
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    beats.push_back({out_last, out_ch, out_data});
                    if (out_last) dump_done = 1;
                end else begin
                    stalled = 1;
                    held = {out_last, out_ch, out_data};
                end
            end
        end
        arm = 1'b0;
        out_ready = 1'b1;
        chk("dump_done", {31'b0, dump_done}, 32'd1);
        @(negedge clk);
        chk("post_dump_valid", {31'b0, out_valid}, 32'd0);
        chk("post_dump_busy", {31'b0, busy}, 32'd0);
        chk("post_dump_trig", {31'b0, triggered}, 32'd0);
    endtask

    task automatic verify(input string tag, input int rows, input int first);
        chk({tag, "_count"}, beats.size(), rows * 6);
        for (int k = 0; k < beats.size() && k < rows * 6; k++) begin
            int r;
            int c;
            logic [19:0] e;
            r = k / 6;
            c = k % 6;
            e = {(r == rows - 1 && c == 5), 3'(c), 16'(first + r + 256 * c)};
            chk({tag, "_beat"}, {12'b0, beats[k]}, {12'b0, e});
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {16'b0, out_data}, 32'd0);
        chk("rst_ch", {29'b0, out_ch}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_trig", {31'b0, triggered}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: trigger on ch0==5, two post rows, full 8-row dump.
        do_arm(3'd0, 16'd5, 16'hFFFF, 3'd2);
        chk("s1_busy", {31'b0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("s1_pretrig", {31'b0, triggered}, 32'd0);
        @(negedge clk);
        chk("s1_trig", {31'b0, triggered}, 32'd1);
        repeat (2) @(negedge clk);
        chk("s1_valid_early", {31'b0, out_valid}, 32'd0);
        collect(0, 200);
        chk("s1_first_valid", first_valid, 32'd1);
        chk("s1_last", {12'b0, beats[47]}, {12'b0, 1'b1, 3'd5, 16'h0507});
        verify("s1", 8, 0);

        // Scenario 1 again with a stalling consumer.
        do_arm(3'd0, 16'd5, 16'hFFFF, 3'd2);
        collect(1, 400);
        verify("s1_stall", 8, 0);

        // Scenario 2: wrap; trigger row 20 with three post rows.
        do_arm(3'd0, 16'd20, 16'hFFFF, 3'd3);
        collect(0, 300);
        chk("s2_trig_row", {12'b0, beats[24]}, {12'b0, 1'b0, 3'd0, 16'd20});
        verify("s2", 8, 16);

        // Scenario 3: mask 0, no post rows -> single row.
        do_arm(3'd0, 16'h1234, 16'h0000, 3'd0);
        collect(0, 100);
        chk("s3_first_valid", first_valid, 32'd2);
        verify("s3", 1, 0);

        // Re-arm while in POST restarts with the new config (ch2 == 0x204).
        do_arm(3'd0, 16'd3, 16'hFFFF, 3'd7);
        repeat (5) @(negedge clk);
        chk("rearm_in_post_trig", {31'b0, triggered}, 32'd1);
        do_arm(3'd2, 16'h0204, 16'hFFFF, 3'd1);
        chk("rearm_cleared_trig", {31'b0, triggered}, 32'd0);
        chk("rearm_busy", {31'b0, busy}, 32'd1);
        collect(0, 200);
        verify("rearm", 6, 0);

        // Arm pulse during DUMP is ignored.
        do_arm(3'd0, 16'd5, 16'hFFFF, 3'd2);
        collect(2, 200);
        verify("arm_in_dump", 8, 0);

        // Asynchronous reset on beat 10, then a clean capture.
        do_arm(3'd0, 16'd5, 16'hFFFF, 3'd2);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        chk("rst_wait_valid", {31'b0, out_valid}, 32'd1);
        repeat (9) @(negedge clk);
        chk("rst_beat10", {16'b0, out_data}, 32'h0301);
        chk("rst_pre_trig", {31'b0, triggered}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_trig", {31'b0, triggered}, 32'd0);
        chk("arst_data", {16'b0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_arm(3'd0, 16'd5, 16'hFFFF, 3'd2);
        collect(0, 200);
        verify("post_rst", 8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
